// File: rtl/alu_pkg.sv
// Shared types and sizes for the ALU result register stage.
package alu_pkg;

  localparam int RESULT_W   = 8;
  localparam int HIST_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    LOCKOUT  = 2'd2,
    WAIT_LOW = 2'd3
  } alu_reg_state_t;

endpackage

// File: rtl/alu_result_reg_sync_rise.sv
// Two-flop synchronizer for an asynchronous button, plus rising-edge detect
// on the synchronized level.
module sync_rise (
  input  logic clk,
  input  logic resetn,
  input  logic d_async,
  output logic level,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= d_async;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign level = r_s2;
  assign rise  = r_s2 & ~r_s2_d;

endmodule

// File: rtl/alu_result_reg.sv
// Result register behind the lab ALU: commits alu_out on a debounced press.
// Optional 4-deep history of commits when ALU_HISTORY_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a synchronized rising edge of capture
// COMMIT   | one cycle; result/history/count take alu_out at the edge
// LOCKOUT  | debounce window, presses ignored while the counter runs
// WAIT_LOW | waiting for the button to be released before re-arming
module alu_result_reg
  import alu_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [RESULT_W-1:0] alu_out,
  input  logic                capture,
  input  logic                clear,
  input  logic [1:0]          hist_sel,
  output logic [RESULT_W-1:0] result,
  output logic [3:0]          acc_b,
  output logic                valid,
  output logic [3:0]          capture_count,
  output logic [RESULT_W-1:0] hist_out
);

  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  logic                w_level;
  logic                w_rise;
  alu_reg_state_t      r_state;
  alu_reg_state_t      w_state_nxt;
  logic [CNT_W-1:0]    r_lock_cnt;
  logic                w_commit;
  logic                w_cnt_dec;
  logic [RESULT_W-1:0] r_result;
  logic                r_valid;
  logic [3:0]          r_count;

  sync_rise u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .d_async (capture),
    .level   (w_level),
    .rise    (w_rise)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_rise) w_state_nxt = COMMIT;
        COMMIT:   w_state_nxt = LOCKOUT;
        LOCKOUT:  if (r_lock_cnt == '0) w_state_nxt = WAIT_LOW;
        WAIT_LOW: if (!w_level) w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // clear wins over a commit landing in the same cycle
  always_comb begin
    w_commit  = (r_state == COMMIT) && !clear;
    w_cnt_dec = (r_state == LOCKOUT) && (r_lock_cnt != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_count    <= 4'd0;
      r_lock_cnt <= '0;
    end else begin
      r_valid <= w_commit;
      if (clear) begin
        r_result   <= '0;
        r_count    <= 4'd0;
        r_lock_cnt <= '0;
      end else if (w_commit) begin
        r_result   <= alu_out;
        r_count    <= r_count + 4'd1;
        r_lock_cnt <= CNT_LOAD;
      end else if (w_cnt_dec) begin
        r_lock_cnt <= r_lock_cnt - 1'b1;
      end
    end
  end

  assign result        = r_result;
  assign acc_b         = r_result[3:0];
  assign valid         = r_valid;
  assign capture_count = r_count;

`ifdef ALU_HISTORY_EN
  logic [RESULT_W-1:0] r_hist [HIST_DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else if (w_commit) begin
      r_hist[0] <= alu_out;
      for (int i = 1; i < HIST_DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  assign hist_out = r_hist[hist_sel];
`else
  // Without history the selector has nothing to choose from.
  logic w_unused_hist_sel;
  assign w_unused_hist_sel = ^hist_sel;
  assign hist_out          = r_result;
`endif

endmodule

// File: tb/tb_alu_result_reg.sv
// Self-checking bench for alu_result_reg: directed scenarios with literal
// expectations plus a randomized run against an event-level reference model.
module tb_alu_result_reg;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] alu_out = 8'h00;
  logic       capture = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] hist_sel = 2'd0;
  logic [7:0] result;
  logic [3:0] acc_b;
  logic       valid;
  logic [3:0] capture_count;
  logic [7:0] hist_out;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  bit chk_en = 1'b0;

  alu_result_reg #(.LOCKOUT_CYCLES(L)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .alu_out       (alu_out),
    .capture       (capture),
    .clear         (clear),
    .hist_sel      (hist_sel),
    .result        (result),
    .acc_b         (acc_b),
    .valid         (valid),
    .capture_count (capture_count),
    .hist_out      (hist_out)
  );

  always #5 clk = ~clk;

  // Reference model: tracks what the button pipeline has seen and when the
  // block is allowed to accept the next press.
  bit         m_s1 = 0, m_s2 = 0, m_s2d = 0;
  bit         m_pending = 0, m_wait = 0, m_rise = 0;
  int         m_lock_left = 0;
  int         m_count = 0;
  bit         m_valid = 0;
  logic [7:0] m_result = 8'h00;
  logic [7:0] m_hist [4] = '{default: 8'h00};

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = 0; m_s2 = 0; m_s2d = 0;
      m_pending = 0; m_wait = 0; m_lock_left = 0;
      m_count = 0; m_valid = 0; m_result = 8'h00;
      for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
    end else begin
      m_rise  = m_s2 && !m_s2d;
      m_valid = 0;
      if (clear) begin
        m_result = 8'h00; m_count = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
        m_pending = 0; m_lock_left = 0; m_wait = 0;
      end else if (m_pending) begin
        m_pending = 0;
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0]   = alu_out;
        m_result    = alu_out;
        m_count     = (m_count + 1) % 16;
        m_valid     = 1;
        m_lock_left = L;
      end else if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_wait = 1;
      end else if (m_wait) begin
        if (!m_s2) m_wait = 0;
      end else if (m_rise) begin
        m_pending = 1;
      end
      m_s2d = m_s2; m_s2 = m_s1; m_s1 = capture;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_result", result, m_result);
      chk("cyc_acc_b", {4'h0, acc_b}, {4'h0, m_result[3:0]});
      chk("cyc_valid", {7'h0, valid}, {7'h0, m_valid});
      chk("cyc_count", {4'h0, capture_count}, 8'(m_count));
`ifdef ALU_HISTORY_EN
      chk("cyc_hist", hist_out, m_hist[hist_sel]);
`else
      chk("cyc_hist", hist_out, m_result);
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) vcount++;
  end

  task automatic press(input logic [7:0] v);
    alu_out = v;
    capture = 1'b1;
    repeat (4) @(negedge clk);
    capture = 1'b0;
    repeat (L + 6) @(negedge clk);
  endtask

  logic [7:0] exp_hist [4];

  initial begin
    alu_out = 8'h5A;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_result", result, 8'h00);
    chk("idle_valid", {7'h0, valid}, 8'h00);
    chk("idle_count", {4'h0, capture_count}, 8'h00);

    // single press: result appears exactly 3 edges after first sample
    vcount = 0;
    alu_out = 8'h3C;
    capture = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("pre_commit_result", result, 8'h00);
    @(posedge clk);
    #1;
    chk("press_result", result, 8'h3C);
    chk("press_acc_b", {4'h0, acc_b}, 8'h0C);
    chk("press_valid", {7'h0, valid}, 8'h01);
    chk("press_count", {4'h0, capture_count}, 8'h01);
    @(posedge clk);
    #1 chk("press_valid_drop", {7'h0, valid}, 8'h00);
    repeat (16) @(negedge clk);
    capture = 1'b0;
    chk("press_pulses", 8'(vcount), 8'd1);
    repeat (L + 6) @(negedge clk);

    // bounce during the debounce window, then held: one commit only
    vcount = 0;
    alu_out = 8'h47;
    capture = 1'b1;
    repeat (3) @(negedge clk);
    capture = 1'b0; @(negedge clk);
    capture = 1'b1; @(negedge clk);
    capture = 1'b0; @(negedge clk);
    capture = 1'b1;
    repeat (50) @(negedge clk);
    chk("bounce_pulses", 8'(vcount), 8'd1);
    chk("bounce_count", {4'h0, capture_count}, 8'h02);
    capture = 1'b0;
    repeat (L + 6) @(negedge clk);
    press(8'h81);
    chk("repress_pulses", 8'(vcount), 8'd2);
    chk("repress_result", result, 8'h81);

    // clear lands in the COMMIT cycle
    vcount = 0;
    alu_out = 8'h99;
    capture = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_result", result, 8'h00);
    chk("clr_valid", {7'h0, valid}, 8'h00);
    chk("clr_count", {4'h0, capture_count}, 8'h00);
    repeat (10) @(negedge clk);
    chk("clr_held_pulses", 8'(vcount), 8'd0);
    capture = 1'b0;
    repeat (6) @(negedge clk);

    // history browse
    press(8'h11); press(8'h22); press(8'h33); press(8'h44); press(8'h55);
`ifdef ALU_HISTORY_EN
    exp_hist = '{8'h55, 8'h44, 8'h33, 8'h22};
`else
    exp_hist = '{8'h55, 8'h55, 8'h55, 8'h55};
`endif
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1 chk("hist_sel", hist_out, exp_hist[s]);
      @(negedge clk);
    end
    hist_sel = 2'd0;

    // count wrap from a cleared state
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    for (int n = 0; n < 15; n++) press(8'(n + 1));
    chk("count_15", {4'h0, capture_count}, 8'h0F);
    press(8'hE7);
    chk("count_wrap", {4'h0, capture_count}, 8'h00);
    chk("wrap_result", result, 8'hE7);

    // async reset mid-LOCKOUT, button held across release
    alu_out = 8'hC3;
    capture = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_result", result, 8'h00);
    chk("arst_acc_b", {4'h0, acc_b}, 8'h00);
    chk("arst_valid", {7'h0, valid}, 8'h00);
    chk("arst_count", {4'h0, capture_count}, 8'h00);
    chk("arst_hist", hist_out, 8'h00);
    @(negedge clk);
    vcount = 0;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_after_reset_pulses", 8'(vcount), 8'd1);
    chk("held_after_reset_result", result, 8'hC3);
    capture = 1'b0;
    repeat (L + 6) @(negedge clk);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      alu_out  = 8'($urandom);
      hist_sel = 2'($urandom);
      if ($urandom_range(0, 6) == 0) capture = ~capture;
      clear = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    clear = 1'b0;
    capture = 1'b0;
    repeat (L + 6) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
